// File: rtl/add_cnt_dff_slices.sv
// Bit-slice reference datapath: ripple-carry adder, synchronous up-counter and
// loadable register, each assembled from replicated one-bit cells.

// Full-adder cell.
module add_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end
endmodule

// Loadable counter-bit cell; toggles when enabled and every lower bit is one.
module cnt_slice (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enab,
    input  logic d,
    input  logic ci,
    output logic q,
    output logic co
);
    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = d;
        else if (enab)
            q_d = q_q ^ ci;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= 1'b0;
        else
            q_q <= q_d;
    end

    assign q  = q_q;
    assign co = q_q & ci;
endmodule

// Enabled D-flip-flop cell.
module dff_slice (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d,
    output logic q
);
    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= 1'b0;
        else
            q_q <= q_d;
    end

    assign q = q_q;
endmodule

module add_cnt_dff_slices #(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] add_a,
    input  logic [DWIDTH-1:0] add_b,
    input  logic              add_ci,
    output logic [DWIDTH-1:0] add_sum,
    output logic              add_co,
    input  logic              cnt_load,
    input  logic              cnt_enab,
    input  logic [CWIDTH-1:0] cnt_in,
    output logic [CWIDTH-1:0] cnt_out,
    output logic              cnt_tc,
    input  logic              reg_load,
    input  logic [DWIDTH-1:0] reg_in,
    output logic [DWIDTH-1:0] reg_out
);
    logic [DWIDTH:0] add_c;
    logic [CWIDTH:0] cnt_c;

    assign add_c[0] = add_ci;
    assign add_co   = add_c[DWIDTH];

    for (genvar i = 0; i < DWIDTH; i++) begin : g_add
        add_slice u_add (
            .a  (add_a[i]),
            .b  (add_b[i]),
            .ci (add_c[i]),
            .s  (add_sum[i]),
            .co (add_c[i+1])
        );
    end

    // Increment chain: bit 0 always sees a carry, so the top carry is the terminal count.
    assign cnt_c[0] = 1'b1;
    assign cnt_tc   = cnt_c[CWIDTH];

    for (genvar i = 0; i < CWIDTH; i++) begin : g_cnt
        cnt_slice u_cnt (
            .clk  (clk),
            .rst  (rst),
            .load (cnt_load),
            .enab (cnt_enab),
            .d    (cnt_in[i]),
            .ci   (cnt_c[i]),
            .q    (cnt_out[i]),
            .co   (cnt_c[i+1])
        );
    end

    for (genvar i = 0; i < DWIDTH; i++) begin : g_reg
        dff_slice u_reg (
            .clk  (clk),
            .rst  (rst),
            .load (reg_load),
            .d    (reg_in[i]),
            .q    (reg_out[i])
        );
    end
endmodule

// File: tb/tb_add_cnt_dff_slices.sv
// Randomised and directed bench for add_cnt_dff_slices against an arithmetic model.
module tb_add_cnt_dff_slices;
    localparam int DW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] add_a, add_b, add_sum;
    logic          add_ci, add_co;
    logic          cnt_load, cnt_enab, cnt_tc;
    logic [CW-1:0] cnt_in, cnt_out;
    logic          reg_load;
    logic [DW-1:0] reg_in, reg_out;

    int checks = 0;
    int errors = 0;

    // Model state: plain integers updated at each rising edge.
    int m_cnt = 0;
    int m_reg = 0;
    bit m_valid = 1'b0;

    add_cnt_dff_slices #(.DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_ci   (add_ci),
        .add_sum  (add_sum),
        .add_co   (add_co),
        .cnt_load (cnt_load),
        .cnt_enab (cnt_enab),
        .cnt_in   (cnt_in),
        .cnt_out  (cnt_out),
        .cnt_tc   (cnt_tc),
        .reg_load (reg_load),
        .reg_in   (reg_in),
        .reg_out  (reg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One rising edge: update the model from the inputs the DUT also sees, then
    // move off the edge so the caller can drive the next cycle.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cnt   = 0;
            m_reg   = 0;
            m_valid = 1'b1;
        end else begin
            if (cnt_load)
                m_cnt = int'(cnt_in);
            else if (cnt_enab)
                m_cnt = (m_cnt + 1) % (1 << CW);
            if (reg_load)
                m_reg = int'(reg_in);
        end
        #1;
    endtask

    // Continuous compare on the falling edge.
    always @(negedge clk) begin
        logic [DW:0] exp_add;
        exp_add = DW'(add_a) + DW'(add_b) + add_ci;
        chk("adder", {add_co, add_sum}, exp_add);
        if (m_valid) begin
            chk("cnt_out", cnt_out, m_cnt);
            chk("cnt_tc", cnt_tc, (m_cnt == (1 << CW) - 1));
            chk("reg_out", reg_out, m_reg);
        end
    end

    initial begin
        rst = 1'b1; cnt_load = 0; cnt_enab = 0; cnt_in = '0;
        reg_load = 0; reg_in = '0; add_a = '0; add_b = '0; add_ci = 0;
        tick();
        chk("rst_cnt", cnt_out, 5'd0);
        chk("rst_tc", cnt_tc, 1'b0);
        chk("rst_reg", reg_out, 8'h00);

        rst = 0; cnt_enab = 1;
        repeat (31) tick();
        chk("cnt_31", cnt_out, 5'd31);
        chk("tc_31", cnt_tc, 1'b1);
        tick();
        chk("cnt_wrap", cnt_out, 5'd0);
        chk("tc_wrap", cnt_tc, 1'b0);

        cnt_enab = 0; cnt_load = 1; cnt_in = 5'd7;
        tick();
        chk("cnt_ld7", cnt_out, 5'd7);
        cnt_enab = 1; cnt_in = 5'h12;
        tick();
        chk("load_beats_enab", cnt_out, 5'h12);
        cnt_enab = 0; cnt_load = 0;
        tick();
        chk("cnt_hold", cnt_out, 5'h12);

        reg_load = 1; reg_in = 8'hA5;
        tick();
        chk("reg_load", reg_out, 8'hA5);
        reg_load = 0; reg_in = 8'h5A;
        tick();
        chk("reg_hold", reg_out, 8'hA5);

        rst = 1; cnt_load = 1; cnt_enab = 1; cnt_in = 5'h1F; reg_load = 1; reg_in = 8'h3C;
        tick();
        chk("rst_mid_cnt", cnt_out, 5'd0);
        chk("rst_mid_reg", reg_out, 8'h00);
        rst = 0; cnt_load = 0; cnt_enab = 0; reg_load = 0;

        add_a = 8'hFF; add_b = 8'h01; add_ci = 0;
        #1;
        chk("add_ff_01_sum", add_sum, 8'h00);
        chk("add_ff_01_co", add_co, 1'b1);
        add_a = 8'h3C; add_b = 8'h5A; add_ci = 1;
        #1;
        chk("add_3c_5a_sum", add_sum, 8'h97);
        chk("add_3c_5a_co", add_co, 1'b0);

        // Adder inputs held while rst toggles; the negedge compare covers each cycle.
        for (int i = 0; i < 6; i++) begin
            rst = i[0];
            tick();
            chk("add_indep_sum", add_sum, 8'h97);
            chk("add_indep_co", add_co, 1'b0);
        end
        rst = 0;

        for (int i = 0; i < 1000; i++) begin
            add_a    = DW'($urandom);
            add_b    = DW'($urandom);
            add_ci   = 1'($urandom);
            rst      = ($urandom_range(0, 31) == 0);
            cnt_load = ($urandom_range(0, 7) == 0);
            cnt_enab = ($urandom_range(0, 3) != 0);
            cnt_in   = CW'($urandom);
            reg_load = 1'($urandom);
            reg_in   = DW'($urandom);
            tick();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_cnt_dff_slices.md
Name: add_cnt_dff_slices

Overview:
- Parameterised bit-slice datapath that bundles the three primitive cell behaviours used across the processor library:
  - the full-adder cell (add), replicated as a ripple-carry adder;
  - the loadable counter-bit cell (cnt), replicated as a synchronous up-counter;
  - the enabled D-flip-flop cell (dff), replicated as a loadable register.
- Serves as the reference implementation and verification target for the cells that alu, counter, register and memory build on.
- The three sections are independent and share only clock and reset.

Parameters:
- DWIDTH, 8, bit width of the adder and the register.
- CWIDTH, 5, bit width of the counter (program-counter width).

Ports:
- clk  input  1  rising-edge clock for the counter and register sections
- rst  input  1  synchronous active-high reset
- add_a  input  DWIDTH  adder operand A
- add_b  input  DWIDTH  adder operand B
- add_ci  input  1  adder carry-in to bit 0
- add_sum  output  DWIDTH  sum
- add_co  output  1  carry-out of the MSB slice
- cnt_load  input  1  parallel load of the counter
- cnt_enab  input  1  count enable
- cnt_in  input  CWIDTH  parallel load value
- cnt_out  output  CWIDTH  counter state
- cnt_tc  output  1  ripple carry out of the MSB slice (terminal count)
- reg_load  input  1  register load enable
- reg_in  input  DWIDTH  register data in
- reg_out  output  DWIDTH  register state

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). There is no asynchronous path.

Adder section (purely combinational, zero latency):
- Slice i: sum_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
- c_0 = add_ci; add_co = c_DWIDTH.
- {add_co, add_sum} == add_a + add_b + add_ci exactly, with unsigned wrap.
- Unaffected by clk and rst.

Counter section (one flop per slice, ripple increment chain):
- Slice i carry-in ci_i: ci_0 = 1; ci_(i+1) = co_i, where co_i = q_i & ci_i (combinational).
- cnt_tc = co_(CWIDTH-1) = ci_0 & all q bits. cnt_tc is high iff the state is all ones, independent of cnt_enab.
- Update at each rising clk edge, in priority order:
  1. rst=1: q <= 0.
  2. else cnt_load=1: q <= cnt_in. Load beats enable.
  3. else cnt_enab=1: q_i <= q_i ^ ci_i, i.e. cnt_out <= cnt_out + 1 mod 2^CWIDTH.
  4. else hold.
- Wrap-around: from all ones, an enabled count gives all zeros.
- Load and enable together: the loaded value wins and no increment is applied that cycle.
- Reset mid-count or mid-load: rst wins; the state is 0 on the next edge.

Register section (one flop per slice):
- Rising clk edge: rst=1 gives reg_out <= 0; else reg_load=1 gives reg_out <= reg_in; else hold.
- Latency is one cycle from reg_in to reg_out.

General:
- Reset values: cnt_out = 0 and reg_out = 0 after the first edge with rst=1.
- Before the first reset edge, cnt_out, cnt_tc and reg_out are X.
- After reset, cnt_tc = 0 (for CWIDTH ≥ 1).
- Implementation requirement: the adder, counter and register are each built structurally as DWIDTH or CWIDTH replicated per-bit slice instances (generate loops), with carries chained exactly as above.
- Outputs are never high-impedance.

Test Plan:
- Adder sweep with DWIDTH=8:
  - a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1.
  - a=8'h3C, b=8'h5A, ci=1 -> sum=8'h97, co=0.
  - Randomised 1000 vectors -> {co,sum} == a+b+ci.
- Counter reset and count with CWIDTH=5:
  - rst for 1 edge -> cnt_out=0, cnt_tc=0.
  - Then enab=1 for 31 edges -> cnt_out=31, cnt_tc=1.
  - 1 more edge -> cnt_out=0, cnt_tc=0 (wrap).
- Counter load priority:
  - cnt_out=7, load=1 and enab=1, cnt_in=5'h12 -> next cnt_out=5'h12, not 5'h13.
  - enab=0, load=0 -> holds 5'h12.
- Reset mid-operation: load=1, enab=1, rst=1, cnt_in=5'h1F on the same edge -> cnt_out=0. The register is cleared on the same edge regardless of reg_load.
- Register:
  - reg_load=1, reg_in=8'hA5 -> reg_out=8'hA5 after 1 edge.
  - reg_load=0, reg_in=8'h5A -> reg_out stays 8'hA5.
  - rst=1 -> 8'h00.
- Adder independence: toggle clk and rst while add inputs are constant -> add_sum and add_co never change.
